uart_rx_to_spi_cmd: RTL and testbench

- Receive-direction counterpart of the SPI-to-UART sample uplink.
- Parses byte frames from the UART receiver into two 12-bit values (data1, data2) and issues one start to the SPI DAC master per valid frame.
- Holds one frame as a pending buffer while the SPI master is busy.
- Reports checksum errors, timeout errors and overruns.

---
 rtl/uart_rx_to_spi_cmd_pkg.sv | 23 ++
 rtl/uart_rx_to_spi_cmd_if.sv | 33 +++
 rtl/uart_rx_to_spi_cmd_parser.sv | 88 ++++++++
 rtl/uart_rx_to_spi_cmd.sv | 131 +++++++++++++
 tb/tb_uart_rx_to_spi_cmd.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_to_spi_cmd_pkg.sv
// Shared definitions for the UART-to-SPI command receive path.
package uart_rx_to_spi_cmd_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         FRAME_LEN     = 5;

   // Parser position inside a frame: SYNC, B0, B1, B2, CHK.
   typedef enum logic [2:0] {
      HUNT     = 3'd0,
      GOT_SYNC = 3'd1,
      GOT_B0   = 3'd2,
      GOT_B1   = 3'd3,
      GOT_B2   = 3'd4
   } parser_state_e;

   // Frame checksum: XOR of the three payload bytes.
   function automatic logic [7:0] frame_chk(input logic [7:0] b0,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2);
      return b0 ^ b1 ^ b2;
   endfunction

endpackage

// File: rtl/uart_rx_to_spi_cmd_if.sv
// Bundle of the byte-receive, SPI-command and status signals.
//
// Handshake semantics: there is no backpressure anywhere on this bundle.
// RxD_data_ready is a one-cycle valid strobe qualifying RxD_data; the
// receiver always accepts it. start is a one-cycle valid strobe qualifying
// data1/data2 toward the SPI master, and done is the master's one-cycle
// completion strobe; the SPI master is treated as "ready" again only after
// done. frame_err and overrun are plain one-cycle event pulses.
interface uart_rx_to_spi_cmd_if;
   import uart_rx_to_spi_cmd_pkg::*;

   logic          RxD_data_ready;
   logic [7:0]    RxD_data;
   logic          done;
   logic          start;
   logic [11:0]   data1;
   logic [11:0]   data2;
   logic          frame_err;
   logic          overrun;
   logic [7:0]    frame_cnt;
   parser_state_e dbg_state;

   modport slave (
      input  RxD_data_ready, RxD_data, done,
      output start, data1, data2, frame_err, overrun, frame_cnt, dbg_state
   );

   modport master (
      output RxD_data_ready, RxD_data, done,
      input  start, data1, data2, frame_err, overrun, frame_cnt, dbg_state
   );

endinterface

// File: rtl/uart_rx_to_spi_cmd_parser.sv
// Frame parser: SYNC/B0/B1/B2/CHK FSM, inter-byte timeout and checksum.
// frame_ok_o is combinational in the cycle the matching CHK byte arrives;
// err_o is registered and pulses the cycle after a bad CHK or a timeout.
module uart_frame_parser
   import uart_rx_to_spi_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CYCLES = 50000,
   parameter int         CNT_W          = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_ready_i,
   input  logic [7:0]    rx_data_i,
   output logic          frame_ok_o,
   output logic [11:0]   d1_o,
   output logic [11:0]   d2_o,
   output logic          err_o,
   output parser_state_e state_o
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   parser_state_e    state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       b0_q, b1_q, b2_q;
   logic             err_q;
   logic             chk_match;

   assign chk_match  = (rx_data_i == frame_chk(b0_q, b1_q, b2_q));
   assign frame_ok_o = (state_q == GOT_B2) && rx_ready_i && chk_match;
   assign d1_o       = {b0_q, b1_q[7:4]};
   assign d2_o       = {b1_q[3:0], b2_q};
   assign err_o      = err_q;
   assign state_o    = state_q;

   // Frame FSM with timeout counter; a sync value inside the payload is data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HUNT;
         cnt_q   <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         b2_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (state_q == HUNT) begin
            cnt_q <= '0;
            if (rx_ready_i && (rx_data_i == SYNC_BYTE)) begin
               state_q <= GOT_SYNC;
            end
         end else if (rx_ready_i) begin
            cnt_q <= '0;
            case (state_q)
               GOT_SYNC: begin
                  b0_q    <= rx_data_i;
                  state_q <= GOT_B0;
               end
               GOT_B0: begin
                  b1_q    <= rx_data_i;
                  state_q <= GOT_B1;
               end
               GOT_B1: begin
                  b2_q    <= rx_data_i;
                  state_q <= GOT_B2;
               end
               GOT_B2: begin
                  state_q <= HUNT;
                  err_q   <= ~chk_match;
               end
               default: state_q <= HUNT;
            endcase
         end else if (cnt_q == TO_LAST) begin
            // Too long without a byte: drop the partial frame.
            state_q <= HUNT;
            cnt_q   <= '0;
            err_q   <= 1'b1;
            b0_q    <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx_to_spi_cmd.sv
// Top level: frame parser plus a one-deep pending buffer and the logic
// that hands decoded frames to the SPI DAC master one at a time.
module uart_rx_to_spi_cmd
   import uart_rx_to_spi_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CYCLES = 50000,
   parameter int         CNT_W          = 16
) (
   input logic               clk,
   input logic               rst,
   uart_rx_to_spi_cmd_if.slave bus
);

   logic          frame_ok;
   logic [11:0]   new_d1, new_d2;
   logic          parse_err;
   parser_state_e parse_state;

   uart_frame_parser #(
      .SYNC_BYTE      (SYNC_BYTE),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_parser (
      .clk        (clk),
      .rst        (rst),
      .rx_ready_i (bus.RxD_data_ready),
      .rx_data_i  (bus.RxD_data),
      .frame_ok_o (frame_ok),
      .d1_o       (new_d1),
      .d2_o       (new_d2),
      .err_o      (parse_err),
      .state_o    (parse_state)
   );

   logic        start_q,      start_d;
   logic        overrun_q,    overrun_d;
   logic [11:0] data1_q,      data1_d;
   logic [11:0] data2_q,      data2_d;
   logic [7:0]  frame_cnt_q,  frame_cnt_d;
   logic        spi_busy_q,   spi_busy_d;
   logic        pend_valid_q, pend_valid_d;
   logic [11:0] pend_d1_q,    pend_d1_d;
   logic [11:0] pend_d2_q,    pend_d2_d;

   logic done_ok;
   logic spi_free;

   // done only counts for a transfer that is actually in flight; a transfer
   // launched this very cycle cannot already be finished.
   assign done_ok  = bus.done && spi_busy_q && !start_q;
   assign spi_free = !spi_busy_q || done_ok;

   // Issue arbitration: pending frame first, then a fresh frame, else buffer or drop.
   always_comb begin
      start_d      = 1'b0;
      overrun_d    = 1'b0;
      data1_d      = data1_q;
      data2_d      = data2_q;
      frame_cnt_d  = frame_cnt_q;
      spi_busy_d   = spi_busy_q;
      pend_valid_d = pend_valid_q;
      pend_d1_d    = pend_d1_q;
      pend_d2_d    = pend_d2_q;

      if (done_ok && pend_valid_q) begin
         start_d     = 1'b1;
         data1_d     = pend_d1_q;
         data2_d     = pend_d2_q;
         frame_cnt_d = frame_cnt_q + 8'd1;
         spi_busy_d  = 1'b1;
         if (frame_ok) begin
            // New frame takes the slot the pending one just vacated.
            pend_d1_d = new_d1;
            pend_d2_d = new_d2;
         end else begin
            pend_valid_d = 1'b0;
         end
      end else if (frame_ok) begin
         if (spi_free && !pend_valid_q) begin
            start_d     = 1'b1;
            data1_d     = new_d1;
            data2_d     = new_d2;
            frame_cnt_d = frame_cnt_q + 8'd1;
            spi_busy_d  = 1'b1;
         end else if (!pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_d1_d    = new_d1;
            pend_d2_d    = new_d2;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (done_ok) begin
         spi_busy_d = 1'b0;
      end
   end

   // Issue-path registers; reset discards any pending or in-flight frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_q      <= 1'b0;
         overrun_q    <= 1'b0;
         data1_q      <= 12'h000;
         data2_q      <= 12'h000;
         frame_cnt_q  <= 8'd0;
         spi_busy_q   <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_d1_q    <= 12'h000;
         pend_d2_q    <= 12'h000;
      end else begin
         start_q      <= start_d;
         overrun_q    <= overrun_d;
         data1_q      <= data1_d;
         data2_q      <= data2_d;
         frame_cnt_q  <= frame_cnt_d;
         spi_busy_q   <= spi_busy_d;
         pend_valid_q <= pend_valid_d;
         pend_d1_q    <= pend_d1_d;
         pend_d2_q    <= pend_d2_d;
      end
   end

   assign bus.start     = start_q;
   assign bus.overrun   = overrun_q;
   assign bus.data1     = data1_q;
   assign bus.data2     = data2_q;
   assign bus.frame_cnt = frame_cnt_q;
   assign bus.frame_err = parse_err;
   assign bus.dbg_state = parse_state;

endmodule

// File: tb/tb_uart_rx_to_spi_cmd.sv
// Self-checking bench for uart_rx_to_spi_cmd: directed scenarios with
// literal expectations, then randomized frames checked every cycle
// against a frame-level model.
module tb_uart_rx_to_spi_cmd;
   import uart_rx_to_spi_cmd_pkg::*;

   localparam int TO = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_rx_to_spi_cmd_if bus ();

   uart_rx_to_spi_cmd #(
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   bit chk_en       = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]    m_bytes[$];
   int            m_idle;
   bit            m_busy;
   logic [11:0]   m_pend_q[$];
   bit            exp_start, exp_err, exp_ovr;
   logic [11:0]   exp_d1, exp_d2;
   logic [7:0]    exp_cnt;
   parser_state_e st_map[5] = '{HUNT, GOT_SYNC, GOT_B0, GOT_B1, GOT_B2};

   task automatic model_issue(input logic [11:0] a, input logic [11:0] b);
      exp_start = 1'b1;
      exp_d1    = a;
      exp_d2    = b;
      exp_cnt   = exp_cnt + 8'd1;
      m_busy    = 1'b1;
   endtask

   always @(posedge clk) begin : model
      bit          ok, done_v;
      logic [7:0]  b0, b1, b2;
      logic [11:0] nd1, nd2, p1, p2;
      if (rst) begin
         m_bytes.delete();
         m_pend_q.delete();
         m_idle = 0; m_busy = 0;
         exp_start = 0; exp_err = 0; exp_ovr = 0;
         exp_d1 = 0; exp_d2 = 0; exp_cnt = 0;
      end else begin
         ok = 0; nd1 = 0; nd2 = 0;
         done_v = bus.done && m_busy && !exp_start;
         exp_start = 0; exp_err = 0; exp_ovr = 0;
         if (bus.RxD_data_ready) begin
            m_idle = 0;
            if (m_bytes.size() == 0) begin
               if (bus.RxD_data == 8'hA5) m_bytes.push_back(bus.RxD_data);
            end else if (m_bytes.size() < FRAME_LEN - 1) begin
               m_bytes.push_back(bus.RxD_data);
            end else begin
               b0 = m_bytes[1]; b1 = m_bytes[2]; b2 = m_bytes[3];
               if (bus.RxD_data == (b0 ^ b1 ^ b2)) begin
                  ok  = 1;
                  nd1 = {b0, b1[7:4]};
                  nd2 = {b1[3:0], b2};
               end else begin
                  exp_err = 1;
               end
               m_bytes.delete();
            end
         end else if (m_bytes.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
               exp_err = 1;
               m_bytes.delete();
               m_idle = 0;
            end
         end
         if (done_v && m_pend_q.size() > 0) begin
            p1 = m_pend_q.pop_front();
            p2 = m_pend_q.pop_front();
            model_issue(p1, p2);
            if (ok) begin m_pend_q.push_back(nd1); m_pend_q.push_back(nd2); end
         end else if (ok) begin
            if ((!m_busy || done_v) && m_pend_q.size() == 0) model_issue(nd1, nd2);
            else if (m_pend_q.size() == 0) begin m_pend_q.push_back(nd1); m_pend_q.push_back(nd2); end
            else exp_ovr = 1;
         end else if (done_v) begin
            m_busy = 0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("start",     bus.start,     exp_start);
         check("data1",     bus.data1,     exp_d1);
         check("data2",     bus.data2,     exp_d2);
         check("frame_err", bus.frame_err, exp_err);
         check("overrun",   bus.overrun,   exp_ovr);
         check("frame_cnt", bus.frame_cnt, exp_cnt);
         check("state",     bus.dbg_state, st_map[m_bytes.size()]);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input bit r, input logic [7:0] d, input bit dn);
      bus.RxD_data_ready = r;
      bus.RxD_data       = d;
      bus.done           = dn;
      @(posedge clk);
      #1;
      bus.RxD_data_ready = 1'b0;
      bus.done           = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(0, 8'h00, 0);
      tick(0, 8'h00, 0);
      rst = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] c, input bit dn_on_chk);
      tick(1, 8'hA5, 0);
      tick(1, b0, 0);
      tick(1, b1, 0);
      tick(1, b2, 0);
      tick(1, c, dn_on_chk);
   endtask

   task automatic rand_tick(input bit r, input logic [7:0] d);
      bit dn;
      dn = ($urandom_range(0, 3) == 0) && !exp_start;
      tick(r, d, dn);
   endtask

   task automatic rand_byte(input logic [7:0] d);
      int g;
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) rand_tick(0, 8'h00);
      rand_tick(1, d);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus.RxD_data_ready = 1'b0;
      bus.RxD_data       = 8'h00;
      bus.done           = 1'b0;
      do_reset();
      chk_en = 1'b1;

      check("reset data1", bus.data1, 12'h000);
      check("reset cnt",   bus.frame_cnt, 8'd0);
      check("reset state", bus.dbg_state, HUNT);

      // Valid frame with SPI idle
      send_frame(8'h12, 8'h34, 8'h56, 8'h70, 0);
      check("f1 start", bus.start, 1'b1);
      check("f1 data1", bus.data1, 12'h123);
      check("f1 data2", bus.data2, 12'h456);
      check("f1 cnt",   bus.frame_cnt, 8'd1);
      tick(0, 8'h00, 0);
      check("f1 start once", bus.start, 1'b0);

      // Checksum error
      send_frame(8'h12, 8'h34, 8'h56, 8'h71, 0);
      check("bad chk err",   bus.frame_err, 1'b1);
      check("bad chk start", bus.start, 1'b0);
      check("bad chk data1", bus.data1, 12'h123);

      // Timeout boundary: byte arriving on the last allowed cycle survives
      do_reset();
      tick(1, 8'hA5, 0);
      tick(1, 8'h12, 0);
      for (int i = 0; i < TO - 1; i++) tick(0, 8'h00, 0);
      tick(1, 8'h34, 0);
      check("late byte err",   bus.frame_err, 1'b0);
      check("late byte state", bus.dbg_state, GOT_B1);
      tick(1, 8'h56, 0);
      tick(1, 8'h70, 0);
      check("late frame start", bus.start, 1'b1);

      // Timeout fires after TO idle cycles
      do_reset();
      tick(1, 8'hA5, 0);
      tick(1, 8'h12, 0);
      for (int i = 0; i < TO - 1; i++) tick(0, 8'h00, 0);
      check("to early err", bus.frame_err, 1'b0);
      tick(0, 8'h00, 0);
      check("to err",   bus.frame_err, 1'b1);
      check("to state", bus.dbg_state, HUNT);
      send_frame(8'hAB, 8'hCD, 8'hEF, 8'h89, 0);
      check("after to data1", bus.data1, 12'hABC);
      check("after to data2", bus.data2, 12'hDEF);

      // Pending and overrun with done withheld
      do_reset();
      send_frame(8'h12, 8'h34, 8'h56, 8'h70, 0);
      send_frame(8'hAB, 8'hCD, 8'hEF, 8'h89, 0);
      check("pend no start", bus.start, 1'b0);
      send_frame(8'h11, 8'h22, 8'h33, 8'h00, 0);
      check("overrun", bus.overrun, 1'b1);
      tick(0, 8'h00, 1);
      check("pend start", bus.start, 1'b1);
      check("pend data1", bus.data1, 12'hABC);
      check("pend data2", bus.data2, 12'hDEF);
      check("pend cnt",   bus.frame_cnt, 8'd2);

      // frame_ok coinciding with done, pending empty
      send_frame(8'h01, 8'h23, 8'h45, 8'h67, 1);
      check("coinc start", bus.start, 1'b1);
      check("coinc data1", bus.data1, 12'h012);
      check("coinc data2", bus.data2, 12'h345);
      check("coinc cnt",   bus.frame_cnt, 8'd3);

      // Reset mid-frame
      tick(1, 8'hA5, 0);
      tick(1, 8'h12, 0);
      rst = 1'b1;
      tick(0, 8'h00, 0);
      rst = 1'b0;
      check("mid rst data1", bus.data1, 12'h000);
      check("mid rst cnt",   bus.frame_cnt, 8'd0);
      check("mid rst state", bus.dbg_state, HUNT);
      send_frame(8'h12, 8'h34, 8'h56, 8'h70, 0);
      check("post rst data1", bus.data1, 12'h123);
      check("post rst cnt",   bus.frame_cnt, 8'd1);

      // Randomized frames, errors, truncations and done pulses
      do_reset();
      for (int n = 0; n < 320; n++) begin
         logic [7:0] b0, b1, b2, c;
         int kind, len;
         b0 = 8'($urandom_range(0, 255));
         b1 = 8'($urandom_range(0, 255));
         b2 = 8'($urandom_range(0, 255));
         c  = frame_chk(b0, b1, b2);
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            c = c ^ (8'h01 << $urandom_range(0, 7));
         end
         if (kind == 1) begin
            rand_byte((b0 == 8'hA5) ? 8'h5A : b0);
         end else if (kind == 2) begin
            len = $urandom_range(1, 4);
            rand_byte(8'hA5);
            if (len > 1) rand_byte(b0);
            if (len > 2) rand_byte(b1);
            if (len > 3) rand_byte(b2);
            for (int i = 0; i < TO + 3; i++) rand_tick(0, 8'h00);
         end else begin
            rand_byte(8'hA5);
            rand_byte(b0);
            rand_byte(b1);
            rand_byte(b2);
            rand_byte(c);
         end
      end
      for (int i = 0; i < 40; i++) rand_tick(0, 8'h00);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
